eje4_barrido: RTL
=================

// Module: eje4_barrido
// PURPOSE
//  Self-checking sweep controller wrapped around the eje4 logic block. Drives all 2^N_IN input
//  combinations onto {A,B,C,D,E,F} and compares the two implementations of each function,
//  (f_1,f_2), (g_1,g_2) and (h_1,h_2), on every vector. Reports the mismatch count, the first
//  failing vector and a pass/done status. Feeds the logic block's inputs and consumes its
//  outputs, replacing the open-loop sweep with on-chip checking.
// PARAMETERS
//  N_IN    6  width of the input vector (A = MSB ... F = LSB)
//  N_FUNC  3  number of function pairs compared (bit0 = f, bit1 = g, bit2 = h)
//  SETTLE  1  cycles each vector is held before it is compared; legal range >= 1
// PORTS
//  clk            in   1         single clock, rising edge
//  reset          in   1         synchronous, active-high reset
//  start          in   1         one-cycle pulse; starts a sweep from IDLE or DONE
//  vec            out  N_IN      {A,B,C,D,E,F} driven to the logic block
//  imp1           in   N_FUNC    {h_1,g_1,f_1}
//  imp2           in   N_FUNC    {h_2,g_2,f_2}
//  busy           out  1         sweep in progress (WAIT or CHECK)
//  done           out  1         sweep finished; held until start or reset
//  pass           out  1         done and err_count == 0
//  err_count      out  N_IN+1    number of vectors with any mismatch, 0..2^N_IN
//  err_valid      out  1         first_err_* hold a captured failure
//  first_err_vec  out  N_IN      vec value at the first mismatch
//  first_err_mask out  N_FUNC    imp1 ^ imp2 at the first mismatch
// BEHAVIOUR
//  - Reset (sync, high): state = IDLE. vec, err_count, first_err_* = 0. busy, done, pass,
//    err_valid = 0. Reset overrides start and takes effect at any point in a sweep.
//  - FSM states are IDLE, WAIT, CHECK and DONE. Every output is registered.
//  - IDLE/DONE + start: vec <= 0; err_count, err_valid, first_err_* cleared; done and pass <= 0;
//    settle counter <= SETTLE-1; next state WAIT.
//  - WAIT: vec held. If cnt == 0, go to CHECK; otherwise cnt--.
//  - CHECK: compare imp1 and imp2 as sampled on the edge that ends CHECK. If mism = imp1^imp2 is
//    non-zero, err_count++. If mism is non-zero and err_valid == 0, capture first_err_vec = vec
//    and first_err_mask = mism, and set err_valid. If vec is all-ones, go to DONE. Otherwise
//    vec++, cnt <= SETTLE-1, and go to WAIT.
//  - DONE: done = 1 and pass = (err_count == 0). vec keeps its last value.
//  - Timing: each vector takes SETTLE+1 cycles. With the start edge as edge 0, done rises after
//    edge 2^N_IN*(SETTLE+1); for the defaults that is edge 128. busy = 1 from edge 0 until done.
//  - start while busy: ignored, with no restart and no counter effect.
//  - start in the same cycle that DONE is entered: ignored, since the FSM is not yet in DONE.
//  - err_count never wraps. Its maximum of 2^N_IN is reachable and fits in N_IN+1 bits.
//  - vec never wraps to 0 inside a sweep. The all-ones vector is the last one checked.
//  - X or Z on imp1/imp2 is not handled. Upstream logic must be settled within SETTLE cycles.
// STRUCTURE
//  - Shared header eje4_defs.vh holds N_IN/N_FUNC defaults and the state encodings
//    (IDLE = 2'd0, WAIT = 2'd1, CHECK = 2'd2, DONE = 2'd3).
//  - One sub-module, eje4_contador: a loadable down-counter for the settle delay, with inputs
//    load/value and output zero. The FSM, vector counter and error capture stay in this module.
//  - The top level instantiates eje4 and eje4_barrido side by side, with vec feeding A..F and
//    the six outputs returning as imp1 and imp2.
// TESTING
//  1. reset high for 2 cycles, then low with no start -> all outputs 0, state remains IDLE,
//     vec = 0.
//  2. imp2 tied to imp1 (golden model), start pulse -> busy for 128 cycles, then done = 1,
//     pass = 1, err_count = 0, err_valid = 0, final vec = 6'h3F.
//  3. imp2 = imp1 ^ 3'b010 only when vec == 6'd37 -> err_count = 1, first_err_vec = 37,
//     first_err_mask = 3'b010, pass = 0.
//  4. imp2 = ~imp1 for every vector -> err_count = 7'd64 (no wrap), first_err_vec = 0,
//     first_err_mask = 3'b111.
//  5. reset pulsed while vec == 20 -> IDLE on the next cycle with all outputs 0; a new start
//     then runs the full 64 vectors and done rises 128 cycles after it.
//  6. start pulsed at vec == 10 -> ignored. start in DONE after scenario 3 -> counters cleared,
//     and a clean second sweep passes. Repeat with SETTLE = 3: done rises after edge 256.

Source files
------------

// File: rtl/eje4_barrido_pkg.sv
// Shared types and defaults for the eje4 sweep checker.
// State encoding is fixed so waveforms read the same across builds.
package eje4_barrido_pkg;

   localparam int N_IN_DEF   = 6;
   localparam int N_FUNC_DEF = 3;
   localparam int SETTLE_DEF = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits needed to hold SETTLE-1 (never less than one).
   function automatic int cnt_width(input int settle);
      return (settle < 3) ? 1 : $clog2(settle);
   endfunction

endpackage

// File: rtl/eje4_contador.sv
// Loadable down-counter that times how long each vector settles.
// It stops at zero and reports it on zero.
module eje4_contador #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/eje4_barrido.sv
// Sweeps every input vector of the eje4 block and compares the two
// implementations of each function, keeping count and the first failure.
module eje4_barrido
   import eje4_barrido_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_FUNC = N_FUNC_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [N_IN-1:0]   vec,
   input  logic [N_FUNC-1:0] imp1,
   input  logic [N_FUNC-1:0] imp2,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              err_valid,
   output logic [N_IN-1:0]   first_err_vec,
   output logic [N_FUNC-1:0] first_err_mask
);

   localparam int CW = cnt_width(SETTLE);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST = '1;

   state_t            state;
   logic              load;
   logic              zero;
   logic              hit;
   logic [N_FUNC-1:0] mism;
   logic [N_IN:0]     err_next;

   assign mism     = imp1 ^ imp2;
   assign hit      = |mism;
   assign err_next = err_count + (N_IN + 1)'(hit);

   // Reload the settle timer at every sweep start and vector step.
   assign load = ((state == IDLE || state == DONE) && start)
              || (state == CHECK && vec != LAST);

   eje4_contador #(
      .W (CW)
   ) u_contador (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .value (RELOAD),
      .zero  (zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         vec            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         err_valid      <= 1'b0;
         first_err_vec  <= '0;
         first_err_mask <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= WAIT;
                  vec            <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  err_valid      <= 1'b0;
                  first_err_vec  <= '0;
                  first_err_mask <= '0;
               end
            end
            WAIT: begin
               if (zero) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (hit) begin
                  err_count <= err_next;
               end
               if (hit && !err_valid) begin
                  err_valid      <= 1'b1;
                  first_err_vec  <= vec;
                  first_err_mask <= mism;
               end
               // The all-ones vector ends the sweep; vec never wraps.
               if (vec == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state <= WAIT;
                  vec   <= vec + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
